// File: rtl/axi_wr_arbiter.sv
// Two-master to one-slave AXI3 write-path arbiter (AW, W, B); one transaction in flight at a time.
// Define AXI_WR_ARB_RR_EN for round-robin arbitration; left undefined, m0 has fixed priority.
module axi_wr_arbiter #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 m0_awvalid,
    input  logic [WIDTH-1:0]     m0_awaddr,
    input  logic [WIDTH/8-1:0]   m0_awid,
    input  logic [WIDTH/8-1:0]   m0_awlen,
    input  logic [SIZE-1:0]      m0_awsize,
    input  logic [SIZE-2:0]      m0_awburst,
    output logic                 m0_awready,
    input  logic                 m0_wvalid,
    input  logic [WIDTH:0]       m0_wdata,
    input  logic [WIDTH/8-1:0]   m0_wstrb,
    input  logic [WIDTH/8-1:0]   m0_wid,
    input  logic                 m0_wlast,
    output logic                 m0_wready,
    output logic                 m0_bvalid,
    output logic [WIDTH/8-1:0]   m0_bid,
    output logic [SIZE-2:0]      m0_bresp,
    input  logic                 m0_bready,

    input  logic                 m1_awvalid,
    input  logic [WIDTH-1:0]     m1_awaddr,
    input  logic [WIDTH/8-1:0]   m1_awid,
    input  logic [WIDTH/8-1:0]   m1_awlen,
    input  logic [SIZE-1:0]      m1_awsize,
    input  logic [SIZE-2:0]      m1_awburst,
    output logic                 m1_awready,
    input  logic                 m1_wvalid,
    input  logic [WIDTH:0]       m1_wdata,
    input  logic [WIDTH/8-1:0]   m1_wstrb,
    input  logic [WIDTH/8-1:0]   m1_wid,
    input  logic                 m1_wlast,
    output logic                 m1_wready,
    output logic                 m1_bvalid,
    output logic [WIDTH/8-1:0]   m1_bid,
    output logic [SIZE-2:0]      m1_bresp,
    input  logic                 m1_bready,

    output logic                 s_awvalid,
    output logic [WIDTH-1:0]     s_awaddr,
    output logic [WIDTH/8-1:0]   s_awid,
    output logic [WIDTH/8-1:0]   s_awlen,
    output logic [SIZE-1:0]      s_awsize,
    output logic [SIZE-2:0]      s_awburst,
    input  logic                 s_awready,
    output logic                 s_wvalid,
    output logic [WIDTH:0]       s_wdata,
    output logic [WIDTH/8-1:0]   s_wstrb,
    output logic [WIDTH/8-1:0]   s_wid,
    output logic                 s_wlast,
    input  logic                 s_wready,
    input  logic                 s_bvalid,
    input  logic [WIDTH/8-1:0]   s_bid,
    input  logic [SIZE-2:0]      s_bresp,
    output logic                 s_bready
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_gnt;
    logic   w_gnt_nxt;
`ifdef AXI_WR_ARB_RR_EN
    logic   r_last;
    logic   w_last_nxt;
`endif

    // Signals of whichever master currently holds the grant
    logic w_awvalid;
    logic w_wvalid;
    logic w_wlast;
    logic w_bready;

    assign w_awvalid = r_gnt ? m1_awvalid : m0_awvalid;
    assign w_wvalid  = r_gnt ? m1_wvalid  : m0_wvalid;
    assign w_wlast   = r_gnt ? m1_wlast   : m0_wlast;
    assign w_bready  = r_gnt ? m1_bready  : m0_bready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
`ifdef AXI_WR_ARB_RR_EN
            r_last  <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
`ifdef AXI_WR_ARB_RR_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
`ifdef AXI_WR_ARB_RR_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (m0_awvalid || m1_awvalid) begin
                    w_state_nxt = ADDR;
`ifdef AXI_WR_ARB_RR_EN
                    if (m0_awvalid && m1_awvalid) w_gnt_nxt = ~r_last;
                    else                          w_gnt_nxt = m1_awvalid;
`else
                    w_gnt_nxt = ~m0_awvalid;
`endif
                end
            end
            ADDR: if (w_awvalid && s_awready) w_state_nxt = DATA;
            DATA: if (w_wvalid && s_wready && w_wlast) w_state_nxt = RESP;
            RESP: begin
                if (s_bvalid && w_bready) begin
                    w_state_nxt = IDLE;
`ifdef AXI_WR_ARB_RR_EN
                    w_last_nxt  = r_gnt;
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m0_bid     = '0;
        m0_bresp   = '0;
        m1_bvalid  = 1'b0;
        m1_bid     = '0;
        m1_bresp   = '0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_awid     = '0;
        s_awlen    = '0;
        s_awsize   = '0;
        s_awburst  = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wid      = '0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;
        case (r_state)
            ADDR: begin
                s_awvalid = w_awvalid;
                s_awaddr  = r_gnt ? m1_awaddr  : m0_awaddr;
                s_awid    = r_gnt ? m1_awid    : m0_awid;
                s_awlen   = r_gnt ? m1_awlen   : m0_awlen;
                s_awsize  = r_gnt ? m1_awsize  : m0_awsize;
                s_awburst = r_gnt ? m1_awburst : m0_awburst;
                if (r_gnt) m1_awready = s_awready;
                else       m0_awready = s_awready;
            end
            DATA: begin
                s_wvalid = w_wvalid;
                s_wdata  = r_gnt ? m1_wdata : m0_wdata;
                s_wstrb  = r_gnt ? m1_wstrb : m0_wstrb;
                s_wid    = r_gnt ? m1_wid   : m0_wid;
                s_wlast  = w_wlast;
                if (r_gnt) m1_wready = s_wready;
                else       m0_wready = s_wready;
            end
            RESP: begin
                s_bready = w_bready;
                if (r_gnt) begin
                    m1_bvalid = s_bvalid;
                    m1_bid    = s_bid;
                    m1_bresp  = s_bresp;
                end else begin
                    m0_bvalid = s_bvalid;
                    m0_bid    = s_bid;
                    m0_bresp  = s_bresp;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Two-master to one-slave arbiter for the AXI3 write path (AW, W and B channels) on the team's `axi` interface signal set. It sits between two `axi.master` ports and one `axi.slave` port, for example a DMA engine and a CPU sharing one memory slave. One write transaction is in flight at a time: the winner owns the slave from AW acceptance through the B handshake.

## Interface
Parameters:
- `WIDTH`, 32 — address width. Derived widths: ID and LEN are WIDTH/8 bits; STRB is WIDTH/8 bits; WDATA is WIDTH+1 bits, matching the shared interface.
- `SIZE`, 3 — AWSIZE is SIZE bits; AWBURST and BRESP are SIZE-1 bits.

Ports (`mN_` is repeated for N = 0 and N = 1):
- `clk`  in  1  — single clock. Everything is sampled on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `mN_awvalid`, `mN_awaddr`, `mN_awid`, `mN_awlen`, `mN_awsize`, `mN_awburst`  in  1/WIDTH/WIDTH/8/WIDTH/8/SIZE/SIZE-1  — master N write address.
- `mN_awready`  out  1  — address accepted.
- `mN_wvalid`, `mN_wdata`, `mN_wstrb`, `mN_wid`, `mN_wlast`  in  1/WIDTH+1/WIDTH/8/WIDTH/8/1  — master N write data.
- `mN_wready`  out  1  — data beat accepted.
- `mN_bvalid`, `mN_bid`, `mN_bresp`  out  1/WIDTH/8/SIZE-1  — write response to master N.
- `mN_bready`  in  1  — master N accepts the response.
- `s_aw*`, `s_w*`, `s_bready`  out  — the same signal set, driven toward the slave.
- `s_awready`, `s_wready`, `s_bvalid`, `s_bid`, `s_bresp`  in  — slave handshake and response inputs.

## Operation
- The FSM has four states: IDLE, ADDR, DATA, RESP. Registers are `state`, `gnt` (0 or 1) and `last` (the master granted most recently).
- IDLE:
  - If any `mN_awvalid` is high, latch the winner into `gnt` and go to ADDR.
  - If only one master requests, it wins.
  - If both request, the master that is not `last` wins.
- ADDR:
  - `s_aw*` = `m[gnt]_aw*` combinationally, and `m[gnt]_awready` = `s_awready`.
  - When the AW handshake completes (`s_awvalid && s_awready`), go to DATA.
- DATA:
  - `s_w*` = `m[gnt]_w*`, and `m[gnt]_wready` = `s_wready`.
  - When a W handshake completes with `wlast` high, go to RESP.
  - Beats are not counted; AWLEN is not checked.
- RESP:
  - `m[gnt]_b*` = `s_b*`, and `s_bready` = `m[gnt]_bready`.
  - When the B handshake completes, set `last` = `gnt` and go to IDLE.
- The non-granted master, and any channel outside its own state, see ready = 0 and bvalid = 0.
- Slave-side valids are 0 outside their own state. Slave-side payloads are don't-care; the implementation drives 0.
- A master that loses arbitration keeps `awvalid` and its payload held, per the AXI rule. The arbiter never drops it.
- `bid` and `wid` pass through unchanged. No ID remapping is done; the two masters must use distinct ID spaces.

## Timing
- Reset values: `state` = IDLE, `gnt` = 0, `last` = 1, so m0 has priority first. All ready, valid and payload outputs are 0.
- Reset asserted mid-transaction returns to IDLE on the next edge. The slave-side transaction is abandoned, and the system must reset the slave too.
- Grant latency: `awvalid` seen in IDLE at edge N gives `s_awvalid` high in cycle N+1. The minimum is 1 cycle.
- All forwarding inside a state is combinational, so there are zero added cycles per beat or per handshake.
- State changes take effect on the edge after the qualifying handshake. Exactly one idle cycle separates back-to-back transactions, because the next arbitration happens in IDLE.
- A one-beat burst with an always-ready slave costs 4 cycles: IDLE, ADDR, DATA, RESP.
- A request that arrives while the arbiter is busy (not IDLE) is ignored until it returns to IDLE. No grant ever changes mid-transaction.
- The W phase may have its first beat valid before the AW phase is done. The arbiter still orders the phases AW, then W; early W beats are simply not yet ready.

## Configuration
- `AXI_WR_ARB_RR_EN` defined: round-robin arbitration as described above. `last` is updated on every B handshake.
- Not defined: fixed priority. m0 always wins simultaneous requests, and the `last` register is removed. m1 is granted only when it requests in IDLE while m0 does not.

## Test plan
- **Single master:** m0 writes AWADDR=0x100, AWLEN=3, four beats 0xA..0xD with an always-ready slave, BRESP=0. Expected:
  - `s_awvalid` rises 1 cycle after `m0_awvalid`;
  - the four beats reach `s_wdata` in order;
  - `m0_bvalid` is seen with bresp 0;
  - m1 sees no ready at any point.
- **Simultaneous requests with RR on, straight after reset:** both masters request, each with a 1-beat burst. Expected: m0 served first, then m1 after one IDLE cycle. Repeat the pair, expect the order m1 then m0 only if m1 is pending alone; with both always pending the order alternates m0, m1, m0, m1.
- **Simultaneous requests with `AXI_WR_ARB_RR_EN` undefined:** both masters continuously request. Expected: m0 is granted every time and m1 is never granted.
- **Backpressure:** `s_awready` low for 3 cycles, `s_wready` toggling, `m0_bready` low for 2 cycles with the slave holding BRESP=2'b10. Expected: payloads held stable, no beat lost or duplicated, m0 receives bresp 2'b10 and BID equal to AWID.
- **Reset mid-burst:** assert reset after beat 2 of 4. Expected: all outputs 0 on the next cycle and `state` = IDLE. A new m1 request after reset is granted with latency 1.
